// File: rtl/intf_array_reader_pkg.sv
// Shared types and constants for the round-robin slot reader.
package intf_array_reader_pkg;

    localparam int          DATA_W_DEFAULT = 8;
    localparam int          MAX_PORTS      = 16;
    localparam logic [15:0] BEAT_COUNT_SAT = 16'hFFFF;

    // Wide enough for the largest supported slot count; the top truncates to its own width.
    typedef logic [$clog2(MAX_PORTS)-1:0] slot_idx_t;

endpackage

// File: rtl/intf_array_reader_rr_arbiter.sv
// Round-robin grant: first requester strictly after the pointer, wrapping to 0.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant
);

    int   idx;
    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx[PTR_W-1:0]]) begin
                grant[idx[PTR_W-1:0]] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intf_array_reader.sv
// Serialises N_PORTS valid/ready slots into one registered output stream.
// Optional beat counter enabled by defining INTF_ARRAY_READER_STATS_EN.
module intf_array_reader
    import intf_array_reader_pkg::*;
#(
    parameter int N_PORTS = 4,
    parameter int DATA_W  = DATA_W_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_PORTS-1:0]          in_valid,
    input  logic [N_PORTS*DATA_W-1:0]   in_data,
    output logic [N_PORTS-1:0]          in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic [$clog2(N_PORTS)-1:0]  out_port,
    input  logic                        out_ready
`ifdef INTF_ARRAY_READER_STATS_EN
    ,
    output logic [15:0]                 beat_count
`endif
);

    localparam int PW = $clog2(N_PORTS);

    // Handshake: a beat moves on any edge where valid && ready are both high;
    // valid never waits on ready, and a presented out beat stays stable until taken.
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic [PW-1:0]     out_port_q, out_port_d;
    logic [PW-1:0]     ptr_q, ptr_d;

    logic [N_PORTS-1:0] grant;
    slot_idx_t          grant_idx;
    logic [DATA_W-1:0]  grant_data;
    logic               out_free;
    logic               slot_xfer;

    rr_arbiter #(
        .N     (N_PORTS),
        .PTR_W (PW)
    ) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .grant (grant)
    );

    assign out_free  = !out_valid_q || out_ready;
    assign in_ready  = (rst_n && out_free) ? grant : '0;
    assign slot_xfer = |in_ready;

    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                grant_idx  = slot_idx_t'(i);
                grant_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_port_d  = out_port_q;
        ptr_d       = ptr_q;
        if (out_free) begin
            out_valid_d = slot_xfer;
            if (slot_xfer) begin
                out_data_d = grant_data;
                out_port_d = grant_idx[PW-1:0];
                ptr_d      = grant_idx[PW-1:0];
            end
        end
    end

    // Pointer resets to the last slot so slot 0 wins the first arbitration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
            ptr_q       <= PW'(N_PORTS - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_port_q  <= out_port_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;

`ifdef INTF_ARRAY_READER_STATS_EN
    logic [15:0] beat_count_q, beat_count_d;

    always_comb begin
        beat_count_d = beat_count_q;
        if (out_valid_q && out_ready && beat_count_q != BEAT_COUNT_SAT) begin
            beat_count_d = beat_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count_q <= '0;
        end else begin
            beat_count_q <= beat_count_d;
        end
    end

    assign beat_count = beat_count_q;
`endif

endmodule

// File: tb/tb_intf_array_reader.sv
// Directed bench for intf_array_reader: per-cycle model compare plus literal beat checks.
module tb_intf_array_reader;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int PW = 2;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [PW-1:0]  out_port;
    logic           out_ready;
`ifdef INTF_ARRAY_READER_STATS_EN
    logic [15:0]    beat_count;
`endif

    intf_array_reader #(.N_PORTS(N), .DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_port  (out_port),
        .out_ready (out_ready)
`ifdef INTF_ARRAY_READER_STATS_EN
        ,
        .beat_count(beat_count)
`endif
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v);
        end
    endtask

    // ---------------- behavioural model and scoreboard ----------------
    logic          m_valid;
    logic [W-1:0]  m_data;
    logic [PW-1:0] m_port;
    int            m_ptr;
    int            m_count;
    logic [PW+W-1:0] exp_q[$];

    int   got_port[$];
    int   got_data[$];
    int   got_cyc[$];
    int   cyc = 0;
    int   first_in_cyc = -1;
    logic [N-1:0] acc_mask = '0;
    logic auto_clr = 1'b0;

    function automatic int rr_pick(input int ptr, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin : compare
        int            g;
        logic          free;
        logic [N-1:0]  exp_rdy;
        logic [PW+W-1:0] e;
        cyc++;
        check("in_ready_onehot0", 32'($onehot0(in_ready)), 32'd1);
        if (!rst_n) begin
            m_valid = 1'b0; m_data = '0; m_port = '0; m_ptr = N - 1; m_count = 0;
            exp_q.delete();
            acc_mask = '0;
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_in_ready", 32'(in_ready), 32'd0);
            check("rst_out_data", 32'(out_data), 32'd0);
            check("rst_out_port", 32'(out_port), 32'd0);
`ifdef INTF_ARRAY_READER_STATS_EN
            check("rst_beat_count", 32'(beat_count), 32'd0);
`endif
        end else begin
            free    = !m_valid || out_ready;
            g       = rr_pick(m_ptr, in_valid);
            exp_rdy = (free && g >= 0) ? N'(1 << g) : '0;
            check("in_ready", 32'(in_ready), 32'(exp_rdy));
            check("out_valid", 32'(out_valid), 32'(m_valid));
            if (m_valid) begin
                check("out_data", 32'(out_data), 32'(m_data));
                check("out_port", 32'(out_port), 32'(m_port));
            end
`ifdef INTF_ARRAY_READER_STATS_EN
            check("beat_count", 32'(beat_count), 32'(m_count));
`endif
            acc_mask = in_valid & in_ready;
            if (first_in_cyc < 0 && |acc_mask) first_in_cyc = cyc;
            if (out_valid && out_ready) begin
                got_port.push_back(int'(out_port));
                got_data.push_back(int'(out_data));
                got_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL beat_dup: got port %0d data %0h expected no beat", out_port, out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_order", 32'({out_port, out_data}), 32'(e));
                end
                if (m_count < 65535) m_count++;
            end
            if (free) begin
                if (g >= 0) begin
                    m_valid = 1'b1;
                    m_data  = in_data[g*W +: W];
                    m_port  = PW'(g);
                    m_ptr   = g;
                    exp_q.push_back({PW'(g), in_data[g*W +: W]});
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (auto_clr) in_valid = in_valid & ~acc_mask;
    endtask

    task automatic clear_log();
        got_port.delete();
        got_data.delete();
        got_cyc.delete();
    endtask

    task automatic expect_beat(input string name, input int k, input int port, input int data);
        if (got_data.size() <= k) begin
            checks++;
            failures++;
            $display("FAIL %s: got %0d beats expected beat %0d", name, got_data.size(), k);
        end else begin
            check({name, "_port"}, 32'(got_port[k]), 32'(port));
            check({name, "_data"}, 32'(got_data[k]), 32'(data));
        end
    endtask

    typedef struct { logic [N-1:0] vmask; logic rdy; } vec_t;
    vec_t vecs[10] = '{
        '{4'b1111, 1'b1}, '{4'b0000, 1'b0}, '{4'b0101, 1'b0}, '{4'b0000, 1'b1},
        '{4'b1010, 1'b1}, '{4'b0011, 1'b0}, '{4'b1100, 1'b1}, '{4'b0001, 1'b1},
        '{4'b1000, 1'b0}, '{4'b0110, 1'b1}
    };

    initial begin : stim
        int n;
        rst_n     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        in_valid = '1;
        #1;
        check("rst_hold_in_ready", 32'(in_ready), 32'd0);
        check("rst_hold_out_valid", 32'(out_valid), 32'd0);

        // All four slots loaded at once: beats leave in slot order, back to back.
        in_data      = {8'h44, 8'h33, 8'h22, 8'h11};
        out_ready    = 1'b1;
        auto_clr     = 1'b1;
        first_in_cyc = -1;
        clear_log();
        rst_n = 1'b1;
        repeat (7) tick();
        check("burst_count", 32'(got_data.size()), 32'd4);
        expect_beat("burst0", 0, 0, 'h11);
        expect_beat("burst1", 1, 1, 'h22);
        expect_beat("burst2", 2, 2, 'h33);
        expect_beat("burst3", 3, 3, 'h44);
        if (got_cyc.size() == 4) begin
            check("burst_latency", 32'(got_cyc[0] - first_in_cyc), 32'd1);
            check("burst_b2b", 32'(got_cyc[3] - got_cyc[0]), 32'd3);
        end

        // Stall: slot 2 beat must hold while out_ready is low, second beat waits.
        clear_log();
        out_ready = 1'b0;
        in_data   = {8'h00, 8'hA5, 8'h00, 8'h00};
        in_valid  = 4'b0100;
        tick();
        in_data  = {8'h00, 8'h5B, 8'h00, 8'h00};
        in_valid = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", 32'(out_data), 32'hA5);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        out_ready = 1'b1;
        repeat (4) tick();
        check("stall_count", 32'(got_data.size()), 32'd2);
        expect_beat("stall0", 0, 2, 'hA5);
        expect_beat("stall1", 1, 2, 'h5B);

        // Wrap-around: after slot 3, search restarts at slot 0.
        clear_log();
        in_data  = {8'hC3, 8'h00, 8'hC1, 8'h00};
        in_valid = 4'b1000;
        repeat (3) tick();
        in_valid = 4'b1010;
        repeat (5) tick();
        check("wrap_count", 32'(got_data.size()), 32'd3);
        expect_beat("wrap0", 0, 3, 'hC3);
        expect_beat("wrap1", 1, 1, 'hC1);
        expect_beat("wrap2", 2, 3, 'hC3);

        // Reset while a beat is stalled: beat vanishes at once, slot 0 first afterwards.
        clear_log();
        out_ready = 1'b0;
        in_data   = {8'h00, 8'h00, 8'h5A, 8'h00};
        in_valid  = 4'b0010;
        repeat (2) tick();
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        check("pre_rst_data", 32'(out_data), 32'h5A);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_in_ready", 32'(in_ready), 32'd0);
        in_data   = {8'hD4, 8'hD3, 8'hD2, 8'hD1};
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        tick();
        clear_log();
        rst_n = 1'b1;
        repeat (6) tick();
        check("post_rst_count", 32'(got_data.size()), 32'd4);
        expect_beat("post_rst0", 0, 0, 'hD1);
        expect_beat("post_rst1", 1, 1, 'hD2);

        // Mixed directed vectors checked by the per-cycle model.
        in_data = {8'h9D, 8'h9C, 8'h9B, 8'h9A};
        foreach (vecs[i]) begin
            in_valid  = in_valid | vecs[i].vmask;
            out_ready = vecs[i].rdy;
            tick();
        end
        out_ready = 1'b1;
        n = 0;
        while ((in_valid != 0 || out_valid) && n < 40) begin
            tick();
            n++;
        end
        if (n >= 40) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got in_valid %0b out_valid %0b expected both idle", in_valid, out_valid);
        end
        tick();
        check("no_lost_beats", 32'(exp_q.size()), 32'd0);

`ifdef INTF_ARRAY_READER_STATS_EN
        auto_clr  = 1'b0;
        in_valid  = 4'b1111;
        out_ready = 1'b1;
        repeat (70000) tick();
        check("beat_count_sat", 32'(beat_count), 32'hFFFF);
        rst_n = 1'b0;
        #1;
        check("beat_count_rst", 32'(beat_count), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #5_000_000;
        failures++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
